// File: rtl/video_pkg.sv
// Shared video-subsystem constants: framebuffer requester ids, address width, read latency.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package video_pkg;

   typedef logic fb_req_id_t;

   localparam fb_req_id_t FB_REQ_CORE     = 1'b0;
   localparam fb_req_id_t FB_REQ_BLIT     = 1'b1;

   localparam int         FB_ADDR_WIDTH   = 15;
   localparam int         FB_READ_LATENCY = 2;

endpackage

// File: rtl/framebuffer_arbiter_if.sv
// Bundles both requester channels, both response channels and the framebuffer RAM port.
// Latency: n/a (wiring only).
// Backpressure: reqN_ready is the only backpressure; responses and RAM port have none.
// Modports: slave = arbiter side, master = requesters plus RAM model.
interface framebuffer_arbiter_if #(
   parameter int ADDR_WIDTH = 15,
   parameter int MAX_WAIT   = 8
);
   localparam int WAIT_WIDTH = $clog2(MAX_WAIT + 1);

   logic                  req0_valid;
   logic                  req0_ready;
   logic                  req0_write;
   logic [ADDR_WIDTH-1:0] req0_address;
   logic [31:0]           req0_write_data;
   logic [3:0]            req0_byte_enable;

   logic                  req1_valid;
   logic                  req1_ready;
   logic                  req1_write;
   logic [ADDR_WIDTH-1:0] req1_address;
   logic [31:0]           req1_write_data;
   logic [3:0]            req1_byte_enable;

   logic                  rsp0_valid;
   logic [31:0]           rsp0_data;
   logic                  rsp1_valid;
   logic [31:0]           rsp1_data;

   logic [ADDR_WIDTH-1:0] mem_address;
   logic [31:0]           mem_write_data;
   logic [3:0]            mem_byte_enable;
   logic                  mem_write_enable;
   logic                  mem_read_enable;
   logic [31:0]           mem_read_data;

   // Aging counter, exported for observability of the fairness mechanism.
   logic [WAIT_WIDTH-1:0] wait_count;

   modport slave (
      input  req0_valid, req0_write, req0_address, req0_write_data, req0_byte_enable,
      input  req1_valid, req1_write, req1_address, req1_write_data, req1_byte_enable,
      input  mem_read_data,
      output req0_ready, req1_ready,
      output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
      output mem_address, mem_write_data, mem_byte_enable, mem_write_enable, mem_read_enable,
      output wait_count
   );

   modport master (
      output req0_valid, req0_write, req0_address, req0_write_data, req0_byte_enable,
      output req1_valid, req1_write, req1_address, req1_write_data, req1_byte_enable,
      output mem_read_data,
      input  req0_ready, req1_ready,
      input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
      input  mem_address, mem_write_data, mem_byte_enable, mem_write_enable, mem_read_enable,
      input  wait_count
   );
endinterface

// File: rtl/read_return_pipe.sv
// Latency-matched {valid, id} shift register steering RAM read data back to its issuer.
// Latency: LATENCY cycles from issue_i to rspN_valid_o.
// Backpressure: none; one issue per cycle, responses cannot be stalled.
// Ports: clock, reset (async high), issue_i/id_i (read strobe + requester), rsp0/1_valid_o.
module read_return_pipe
   import video_pkg::*;
#(
   parameter int LATENCY = FB_READ_LATENCY
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       issue_i,
   input  fb_req_id_t id_i,
   output logic       rsp0_valid_o,
   output logic       rsp1_valid_o
);

   logic [LATENCY-1:0] valid_q;
   logic [LATENCY-1:0] id_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         id_q    <= '0;
      end else begin
         valid_q[0] <= issue_i;
         id_q[0]    <= id_i;
         for (int i = 1; i < LATENCY; i++) begin
            valid_q[i] <= valid_q[i-1];
            id_q[i]    <= id_q[i-1];
         end
      end
   end

   assign rsp0_valid_o = valid_q[LATENCY-1] && (id_q[LATENCY-1] == FB_REQ_CORE);
   assign rsp1_valid_o = valid_q[LATENCY-1] && (id_q[LATENCY-1] == FB_REQ_BLIT);

endmodule

// File: rtl/framebuffer_arbiter.sv
// Shares the framebuffer RAM port between core bus (fixed priority) and blit engine (aged).
// Latency: grant and RAM strobe in the handshake cycle; read data READ_LATENCY cycles later.
// Backpressure: reqN_ready low stalls a requester; blit preempts after MAX_WAIT stalled cycles.
// Ports: clock, reset (async high), bus (framebuffer_arbiter_if.slave: requests, responses, RAM).
module framebuffer_arbiter
   import video_pkg::*;
#(
   parameter int ADDR_WIDTH   = FB_ADDR_WIDTH,
   parameter int READ_LATENCY = FB_READ_LATENCY,
   parameter int MAX_WAIT     = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   framebuffer_arbiter_if.slave   bus
);

   localparam int WAIT_WIDTH = $clog2(MAX_WAIT + 1);
   localparam logic [WAIT_WIDTH-1:0] WAIT_LIMIT = WAIT_WIDTH'(MAX_WAIT);

   logic [WAIT_WIDTH-1:0] wait_count_q, wait_count_d;
   logic                  grant_vld;
   fb_req_id_t            grant_id;
   logic                  sel_write;
   logic [ADDR_WIDTH-1:0] sel_address;
   logic [31:0]           sel_write_data;
   logic [3:0]            sel_byte_enable;

   // Grant is held off while reset is high so no handshake can slip through
   // combinationally during reset.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = FB_REQ_CORE;
      if (!reset) begin
         if (bus.req1_valid && (wait_count_q == WAIT_LIMIT)) begin
            grant_vld = 1'b1;
            grant_id  = FB_REQ_BLIT;
         end else if (bus.req0_valid) begin
            grant_vld = 1'b1;
            grant_id  = FB_REQ_CORE;
         end else if (bus.req1_valid) begin
            grant_vld = 1'b1;
            grant_id  = FB_REQ_BLIT;
         end
      end
   end

   assign bus.req0_ready = grant_vld && (grant_id == FB_REQ_CORE);
   assign bus.req1_ready = grant_vld && (grant_id == FB_REQ_BLIT);

   // Aging counter: counts blit stall cycles, saturating rather than wrapping
   // so the preemption condition stays asserted until the blit is served.
   always_comb begin
      wait_count_d = wait_count_q;
      if (!bus.req1_valid || bus.req1_ready) begin
         wait_count_d = '0;
      end else if (wait_count_q != WAIT_LIMIT) begin
         wait_count_d = wait_count_q + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wait_count_q <= '0;
      end else begin
         wait_count_q <= wait_count_d;
      end
   end

   assign bus.wait_count = wait_count_q;

   // Payload mux; zeros when nothing is granted.
   always_comb begin
      sel_write       = 1'b0;
      sel_address     = '0;
      sel_write_data  = '0;
      sel_byte_enable = '0;
      if (grant_vld && (grant_id == FB_REQ_CORE)) begin
         sel_write       = bus.req0_write;
         sel_address     = bus.req0_address;
         sel_write_data  = bus.req0_write_data;
         sel_byte_enable = bus.req0_byte_enable;
      end else if (grant_vld) begin
         sel_write       = bus.req1_write;
         sel_address     = bus.req1_address;
         sel_write_data  = bus.req1_write_data;
         sel_byte_enable = bus.req1_byte_enable;
      end
   end

   assign bus.mem_address      = sel_address;
   assign bus.mem_write_data   = sel_write_data;
   assign bus.mem_byte_enable  = sel_byte_enable;
   assign bus.mem_write_enable = grant_vld && sel_write;
   assign bus.mem_read_enable  = grant_vld && !sel_write;

   read_return_pipe #(
      .LATENCY (READ_LATENCY)
   ) u_return (
      .clock        (clock),
      .reset        (reset),
      .issue_i      (bus.mem_read_enable),
      .id_i         (grant_id),
      .rsp0_valid_o (bus.rsp0_valid),
      .rsp1_valid_o (bus.rsp1_valid)
   );

   // Both channels see the RAM data; only the matching rspN_valid qualifies it.
   assign bus.rsp0_data = bus.mem_read_data;
   assign bus.rsp1_data = bus.mem_read_data;

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Directed bench for framebuffer_arbiter with a READ_LATENCY-cycle RAM model.
// Latency: n/a.
// Backpressure: n/a.
module tb_framebuffer_arbiter;

   localparam int AW = 15;
   localparam int RL = 2;
   localparam int MW = 8;

   logic clock = 1'b0;
   logic reset = 1'b1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   framebuffer_arbiter_if #(.ADDR_WIDTH(AW), .MAX_WAIT(MW)) bus ();

   framebuffer_arbiter #(
      .ADDR_WIDTH   (AW),
      .READ_LATENCY (RL),
      .MAX_WAIT     (MW)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // RAM model: data captured at the issue edge, visible RL cycles after issue.
   logic [31:0] ram [0:255];
   logic [31:0] rd_pipe [RL];

   always @(posedge clock) begin
      for (int i = RL - 1; i > 0; i--) rd_pipe[i] <= rd_pipe[i-1];
      rd_pipe[0] <= ram[bus.mem_address[7:0]];
   end

   assign bus.mem_read_data = rd_pipe[RL-1];

   task automatic drive0(input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [31:0] d, input logic [3:0] be);
      bus.req0_valid = v; bus.req0_write = w; bus.req0_address = a;
      bus.req0_write_data = d; bus.req0_byte_enable = be;
   endtask

   task automatic drive1(input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [31:0] d, input logic [3:0] be);
      bus.req1_valid = v; bus.req1_write = w; bus.req1_address = a;
      bus.req1_write_data = d; bus.req1_byte_enable = be;
   endtask

   task automatic idle();
      drive0(1'b0, 1'b0, '0, '0, '0);
      drive1(1'b0, 1'b0, '0, '0, '0);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      drive0(1'b1, 1'b0, 15'h0001, '0, 4'hF);
      drive1(1'b1, 1'b0, 15'h0002, '0, 4'hF);
      @(negedge clock);
      n_checks++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
         n_fail++; $display("FAIL reset_ready: got %b expected 00", {bus.req0_ready, bus.req1_ready});
      end
      n_checks++;
      if ({bus.rsp0_valid, bus.rsp1_valid, bus.mem_write_enable, bus.mem_read_enable} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_outputs: got %b expected 0000",
            {bus.rsp0_valid, bus.rsp1_valid, bus.mem_write_enable, bus.mem_read_enable});
      end
      n_checks++;
      if (bus.wait_count !== '0) begin
         n_fail++; $display("FAIL reset_wait_count: got %0d expected 0", bus.wait_count);
      end
      step();
      reset = 1'b0;
      idle();
   endtask

   task automatic test_single_read();
      ram[8'h10] = 32'hDEADBEEF;
      drive0(1'b1, 1'b0, 15'h0010, '0, 4'hF);
      @(negedge clock);
      n_checks++;
      if ({bus.req0_ready, bus.req1_ready, bus.mem_read_enable, bus.mem_write_enable} !== 4'b1010
          || bus.mem_address !== 15'h0010) begin
         n_fail++; $display("FAIL single_read_issue: rdy0/rdy1/re/we=%b addr=%h expected 1010 addr=0010",
            {bus.req0_ready, bus.req1_ready, bus.mem_read_enable, bus.mem_write_enable}, bus.mem_address);
      end
      step(); idle();
      @(negedge clock);
      n_checks++;
      if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin
         n_fail++; $display("FAIL single_read_early: rsp valids %b expected 00", {bus.rsp0_valid, bus.rsp1_valid});
      end
      step();
      @(negedge clock);
      n_checks++;
      if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b10 || bus.rsp0_data !== 32'hDEADBEEF) begin
         n_fail++; $display("FAIL single_read_rsp: valids %b data %h expected 10 DEADBEEF",
            {bus.rsp0_valid, bus.rsp1_valid}, bus.rsp0_data);
      end
      step();
      @(negedge clock);
      n_checks++;
      if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin
         n_fail++; $display("FAIL single_read_pulse: valids %b expected 00", {bus.rsp0_valid, bus.rsp1_valid});
      end
      step();
   endtask

   task automatic test_write();
      drive1(1'b1, 1'b1, 15'h0020, 32'h11223344, 4'b0101);
      @(negedge clock);
      n_checks++;
      if ({bus.req0_ready, bus.req1_ready, bus.mem_write_enable, bus.mem_read_enable} !== 4'b0110
          || bus.mem_address !== 15'h0020 || bus.mem_write_data !== 32'h11223344
          || bus.mem_byte_enable !== 4'b0101) begin
         n_fail++; $display("FAIL write_issue: rdy/we/re=%b addr=%h data=%h be=%b expected 0110 0020 11223344 0101",
            {bus.req0_ready, bus.req1_ready, bus.mem_write_enable, bus.mem_read_enable},
            bus.mem_address, bus.mem_write_data, bus.mem_byte_enable);
      end
      step(); idle();
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         n_checks++;
         if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin
            n_fail++; $display("FAIL write_no_rsp cycle %0d: valids %b expected 00", c, {bus.rsp0_valid, bus.rsp1_valid});
         end
         if (c == 0) begin
            n_checks++;
            if ({bus.mem_write_enable, bus.mem_read_enable} !== 2'b00 || bus.mem_address !== '0) begin
               n_fail++; $display("FAIL idle_outputs: we/re=%b addr=%h expected 00 0000",
                  {bus.mem_write_enable, bus.mem_read_enable}, bus.mem_address);
            end
         end
         step();
      end
   endtask

   task automatic test_priority();
      logic exp1;
      drive0(1'b1, 1'b1, 15'h0030, 32'hA0A0A0A0, 4'hF);
      drive1(1'b1, 1'b1, 15'h0031, 32'hB1B1B1B1, 4'hF);
      for (int c = 0; c < 30; c++) begin
         exp1 = (c == 8) || (c == 17) || (c == 26);
         @(negedge clock);
         n_checks++;
         if ({bus.req0_ready, bus.req1_ready} !== {~exp1, exp1}) begin
            n_fail++; $display("FAIL priority cycle %0d: rdy0/rdy1=%b expected %b",
               c, {bus.req0_ready, bus.req1_ready}, {~exp1, exp1});
         end
         step();
      end
      idle();
      step();
   endtask

   task automatic test_back_to_back();
      ram[8'h41] = 32'hAAAA0001;
      ram[8'h42] = 32'hBBBB0002;
      ram[8'h43] = 32'hCCCC0003;
      drive0(1'b1, 1'b0, 15'h0041, '0, 4'hF);
      @(negedge clock); step();
      drive0(1'b0, 1'b0, '0, '0, '0);
      drive1(1'b1, 1'b0, 15'h0042, '0, 4'hF);
      @(negedge clock);
      n_checks++;
      if (bus.req1_ready !== 1'b1) begin
         n_fail++; $display("FAIL b2b_grant1: rdy1=%b expected 1", bus.req1_ready);
      end
      step();
      drive1(1'b0, 1'b0, '0, '0, '0);
      drive0(1'b1, 1'b0, 15'h0043, '0, 4'hF);
      @(negedge clock);
      n_checks++;
      if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b10 || bus.rsp0_data !== 32'hAAAA0001) begin
         n_fail++; $display("FAIL b2b_rsp_A: valids %b data %h expected 10 AAAA0001",
            {bus.rsp0_valid, bus.rsp1_valid}, bus.rsp0_data);
      end
      step(); idle();
      @(negedge clock);
      n_checks++;
      if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b01 || bus.rsp1_data !== 32'hBBBB0002) begin
         n_fail++; $display("FAIL b2b_rsp_B: valids %b data %h expected 01 BBBB0002",
            {bus.rsp0_valid, bus.rsp1_valid}, bus.rsp1_data);
      end
      step();
      @(negedge clock);
      n_checks++;
      if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b10 || bus.rsp0_data !== 32'hCCCC0003) begin
         n_fail++; $display("FAIL b2b_rsp_C: valids %b data %h expected 10 CCCC0003",
            {bus.rsp0_valid, bus.rsp1_valid}, bus.rsp0_data);
      end
      step();
   endtask

   task automatic test_reset_outstanding();
      int seen;
      ram[8'h50] = 32'h55555555;
      drive0(1'b1, 1'b0, 15'h0050, '0, 4'hF);
      @(negedge clock); step();
      reset = 1'b1;
      drive1(1'b1, 1'b0, 15'h0051, '0, 4'hF);
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         n_checks++;
         if ({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid,
              bus.mem_write_enable, bus.mem_read_enable} !== 6'b000000 || bus.mem_address !== '0) begin
            n_fail++; $display("FAIL reset_mid cycle %0d: rdy/rsp/we/re=%b addr=%h expected 000000 0000", c,
               {bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid,
                bus.mem_write_enable, bus.mem_read_enable}, bus.mem_address);
         end
         step();
      end
      reset = 1'b0;
      drive0(1'b1, 1'b1, 15'h0052, 32'h12345678, 4'hF);
      drive1(1'b0, 1'b0, '0, '0, '0);
      @(negedge clock);
      n_checks++;
      if ({bus.req0_ready, bus.mem_write_enable} !== 2'b11) begin
         n_fail++; $display("FAIL reset_first_grant: rdy0/we=%b expected 11", {bus.req0_ready, bus.mem_write_enable});
      end
      step(); idle();
      seen = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         if (bus.rsp0_valid || bus.rsp1_valid) seen++;
         step();
      end
      n_checks++;
      if (seen != 0) begin
         n_fail++; $display("FAIL reset_discard: %0d response cycles seen, expected 0", seen);
      end
   endtask

   task automatic test_wait_restart();
      logic exp1;
      drive0(1'b1, 1'b1, 15'h0060, 32'h0, 4'hF);
      drive1(1'b1, 1'b1, 15'h0061, 32'h1, 4'hF);
      for (int c = 0; c < 5; c++) begin
         @(negedge clock); step();
      end
      drive1(1'b0, 1'b1, 15'h0061, 32'h1, 4'hF);
      @(negedge clock);
      n_checks++;
      if (bus.wait_count !== 4'd5) begin
         n_fail++; $display("FAIL wait_before_drop: got %0d expected 5", bus.wait_count);
      end
      step();
      drive1(1'b1, 1'b1, 15'h0061, 32'h1, 4'hF);
      @(negedge clock);
      n_checks++;
      if (bus.wait_count !== 4'd0) begin
         n_fail++; $display("FAIL wait_after_drop: got %0d expected 0", bus.wait_count);
      end
      for (int c = 0; c < 9; c++) begin
         if (c > 0) @(negedge clock);
         exp1 = (c == 8);
         n_checks++;
         if ({bus.req0_ready, bus.req1_ready} !== {~exp1, exp1}) begin
            n_fail++; $display("FAIL wait_restart cycle %0d: rdy0/rdy1=%b expected %b",
               c, {bus.req0_ready, bus.req1_ready}, {~exp1, exp1});
         end
         step();
      end
      idle();
      step();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 32'h0;
      idle();
      test_reset();
      test_single_read();
      test_write();
      test_priority();
      test_back_to_back();
      test_reset_outstanding();
      test_wait_restart();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
